// File: rtl/cpu_mem_loader.sv
// Host boot loader in front of the CPU memory write port: streams host words into
// consecutive addresses while stalling the CPU, and passes CPU stores through when idle.
//   state  | meaning
//   S_IDLE | CPU owns the memory write port
//   S_LOAD | accepting host words, CPU stalled
//   S_DONE | final registered write issued, done pulse
//   S_ERR  | rejected load, error flag raised
module cpu_mem_loader #(
  parameter int DEPTH     = 512,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_word_count,
  input  logic        i_in_valid,
  input  logic [15:0] i_in_data,
  output logic        o_in_ready,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_d_addr,
  input  logic [15:0] i_cpu_wrt_data,
  output logic        o_mem_we,
  output logic [15:0] o_mem_d_addr,
  output logic [15:0] o_mem_wrt_data,
  output logic        o_cpu_stall,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr, r_cnt, r_wc, r_checksum;
  logic [15:0] r_wr_addr, r_wr_data;
  logic        r_wr_we, r_error;

  logic        w_start_acc, w_start_zero, w_start_err, w_xfer, w_last;
  logic [31:0] w_end;

  // Range check done in 32 bits so a large word_count cannot wrap past DEPTH
  assign w_end        = 32'(BASE_ADDR) + {16'd0, i_word_count};
  assign w_start_acc  = (r_state == S_IDLE) && i_start;
  assign w_start_zero = (i_word_count == 16'd0);
  assign w_start_err  = (w_end > 32'(DEPTH));
  assign w_xfer       = (r_state == S_LOAD) && i_in_valid;
  assign w_last       = w_xfer && ((r_cnt + 16'd1) == r_wc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_in_ready     = 1'b0;
    o_cpu_stall    = 1'b0;
    o_done         = 1'b0;
    o_busy         = 1'b1;
    o_mem_we       = r_wr_we;
    o_mem_d_addr   = r_wr_addr;
    o_mem_wrt_data = r_wr_data;
    case (r_state)
      S_IDLE: begin
        o_busy         = 1'b0;
        o_mem_we       = i_cpu_we;
        o_mem_d_addr   = i_cpu_d_addr;
        o_mem_wrt_data = i_cpu_wrt_data;
        if (i_start) begin
          if (w_start_zero)     w_state_nxt = S_DONE;
          else if (w_start_err) w_state_nxt = S_ERR;
          else                  w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        o_in_ready  = 1'b1;
        o_cpu_stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_cpu_stall = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        o_mem_we    = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 16'd0;
      r_cnt      <= 16'd0;
      r_wc       <= 16'd0;
      r_checksum <= 16'd0;
      r_wr_we    <= 1'b0;
      r_wr_addr  <= 16'd0;
      r_wr_data  <= 16'd0;
      r_error    <= 1'b0;
    end else begin
      r_wr_we <= w_xfer;
      if (w_xfer) begin
        r_wr_addr  <= r_addr;
        r_wr_data  <= i_in_data;
        r_addr     <= r_addr + 16'd1;
        r_cnt      <= r_cnt + 16'd1;
        r_checksum <= r_checksum + i_in_data;
      end
      if (w_start_acc) begin
        if (w_start_zero) begin
          r_checksum <= 16'd0;
          r_error    <= 1'b0;
        end else if (w_start_err) begin
          r_error <= 1'b1;
        end else begin
          r_addr     <= 16'(BASE_ADDR);
          r_cnt      <= 16'd0;
          r_wc       <= i_word_count;
          r_checksum <= 16'd0;
          r_error    <= 1'b0;
        end
      end
    end
  end

  assign o_error    = r_error;
  assign o_checksum = r_checksum;

endmodule
